mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 resetn  in  1  synchronous active-low reset.
REQ-004 op_valid  in  1  EX-stage instruction is a HI/LO op; held by upstream while stall=1.
REQ-005 op  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU, others NOP.
REQ-006 src_a, src_b  in  32 each  rs and rt operands.
REQ-007 ex_flush  in  1  kill the EX instruction (exception or eret).
REQ-008 stall  out  1  freeze the EX stage and upstream stages.
REQ-009 hi, lo  out  32 each  architectural HI/LO registers.
REQ-010 div_en, div_sign, div_cancel  out  1 each  divider start, signed select and abort.
REQ-011 div_a, div_b  out  32 each  dividend and divisor to the divider.
REQ-012 div_q, div_r  in  32 each  quotient and remainder from the divider.
REQ-013 div_finish  in  1  one-cycle result-valid from the divider.

Function
REQ-014 The FSM SHALL have states IDLE, MUL1, MUL2, DIVW and DONE.
REQ-015 IDLE: op_valid & !ex_flush & op in {1,2} (or 7-10 when enabled) -> MUL1; op in {3,4} -> DIVW.
REQ-016 The accept cycle of DIV/DIVU SHALL drive div_en=1, div_sign=(op==3), div_a=src_a and div_b=src_b; div_en SHALL be 0 in every other cycle.
REQ-017 MUL1 SHALL register two partial products, src_a×src_b[15:0] and src_a×src_b[31:16], with 33-bit sign/zero extension per op; MUL1 -> MUL2.
REQ-018 MUL2 SHALL sum the shifted partials into a 64-bit product, write {hi,lo}, then go to DONE.
REQ-019 DIVW SHALL wait for div_finish, then write hi=div_r and lo=div_q and go to DONE.
REQ-020 Divide by zero SHALL pass the divider outputs through unchanged (architecturally undefined).
REQ-021 DONE SHALL ignore op_valid and op and go to IDLE unconditionally, so a held instruction is never relaunched.
REQ-022 stall = (IDLE & op_valid & !ex_flush & multicycle op) | MUL1 | MUL2 | DIVW; stall SHALL be 0 in DONE.
REQ-023 Latency, with accept at cycle T:
- MULT-class: HI/LO written at the end of T+2; stall is high for 3 cycles.
- DIV-class: div_finish arrives at T+17; HI/LO written at the end of T+17; stall is high for 18 cycles.
REQ-024 MTHI/MTLO in IDLE with op_valid & !ex_flush SHALL write hi/lo from src_a at the next edge, with no stall.
REQ-025 ex_flush in MUL1, MUL2 or DIVW SHALL return the FSM to IDLE next cycle with no HI/LO write; in DIVW it SHALL also assert div_cancel=1 for that cycle.
REQ-026 ex_flush in DONE SHALL NOT revert HI/LO, because the instruction has already completed.
REQ-027 If ex_flush and div_finish coincide in DIVW, the flush SHALL win: no write, div_cancel=1.
REQ-028 div_cancel SHALL be 0 in every other case.

Reset
REQ-029 When resetn=0 at a clock edge, the block SHALL load state=IDLE and hi=lo=0, and clear the partial-product registers.
REQ-030 During and after reset, stall, div_en and div_cancel SHALL be 0 until a new op is accepted.
REQ-031 Reset in any state, including DIVW, SHALL abandon the operation without asserting div_cancel; the divider is reset by the same resetn.

Configuration
REQ-032 Macro MDU_MADD_EN SHALL control ops 7-10.
REQ-033 With MDU_MADD_EN defined, ops 7-10 SHALL follow the MULT timing, and MUL2 SHALL write {hi,lo} ± product (signed for 7/9, unsigned for 8/10), wrapping modulo 2^64.
REQ-034 Without MDU_MADD_EN, ops 7-10 SHALL behave as NOP: no stall, no write, and the accumulate adder is absent.

Verification
REQ-035 MULT src_a=0xFFFFFFFF, src_b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE, stall high for exactly 3 cycles.
REQ-036 MULTU, same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-037 DIV src_a=0xFFFFFFF9 (-7), src_b=2, real divider attached -> single div_en pulse; then lo=0xFFFFFFFD, hi=0xFFFFFFFF, stall high for exactly 18 cycles.
REQ-038 DIVU 100/7, with ex_flush pulsed at T+5 -> div_cancel=1 at T+5, FSM in IDLE at T+6, hi/lo unchanged, stall=0 from T+6.
REQ-039 MTHI 0x12345678, then MTLO 0x9ABCDEF0 back-to-back -> hi then lo updated on consecutive edges, stall never asserted.
REQ-040 With MDU_MADD_EN, {hi,lo}=1, then MADD 3×4 -> {hi,lo}=0x000000000000000D.
REQ-041 Without MDU_MADD_EN, the same MADD -> {hi,lo}=1, no stall.

Source files
------------

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: HI/LO multiply/divide sequencer for the EX stage, driving an external divider.
// Define MDU_MADD_EN to build the MADD/MADDU/MSUB/MSUBU accumulate ops (7-10).
module mdu_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [3:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        ex_flush,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_en,
    output logic        div_sign,
    output logic        div_cancel,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    input  logic        div_finish
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL1 = 3'd1,
        MUL2 = 3'd2,
        DIVW = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               go_s;
    logic               is_mul_s;
    logic               is_div_s;
    logic               is_signed_s;
    logic               mul_signed_r;
    logic signed [32:0] a_ext_s;
    logic signed [16:0] b_lo_ext_s;
    logic signed [16:0] b_hi_ext_s;
    logic signed [49:0] pp_lo_s;
    logic signed [49:0] pp_hi_s;
    logic signed [49:0] pp_lo_r;
    logic signed [49:0] pp_hi_r;
    logic [63:0]        product_s;
    logic [63:0]        mul_res_s;
    logic [31:0]        hi_nxt_s;
    logic [31:0]        lo_nxt_s;
`ifdef MDU_MADD_EN
    logic               acc_en_s;
    logic               acc_sub_s;
    logic               acc_en_r;
    logic               acc_sub_r;
`endif

    // Opcode decode and the IDLE accept qualifier.
    always_comb begin
        go_s        = 1'b0;
        is_mul_s    = 1'b0;
        is_div_s    = 1'b0;
        is_signed_s = 1'b0;
`ifdef MDU_MADD_EN
        acc_en_s    = 1'b0;
        acc_sub_s   = 1'b0;
`endif
        if (state_r == IDLE) begin
            go_s = op_valid & ~ex_flush;
        end else begin
            go_s = 1'b0;
        end
        case (op)
            OP_MULT: begin
                is_mul_s    = 1'b1;
                is_signed_s = 1'b1;
            end
            OP_MULTU: is_mul_s = 1'b1;
            OP_DIV:   is_div_s = 1'b1;
            OP_DIVU:  is_div_s = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD: begin
                is_mul_s    = 1'b1;
                is_signed_s = 1'b1;
                acc_en_s    = 1'b1;
            end
            OP_MADDU: begin
                is_mul_s    = 1'b1;
                acc_en_s    = 1'b1;
            end
            OP_MSUB: begin
                is_mul_s    = 1'b1;
                is_signed_s = 1'b1;
                acc_en_s    = 1'b1;
                acc_sub_s   = 1'b1;
            end
            OP_MSUBU: begin
                is_mul_s    = 1'b1;
                acc_en_s    = 1'b1;
                acc_sub_s   = 1'b1;
            end
`endif
            default: is_mul_s = 1'b0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Multiply flavour captured at accept so later states do not depend on the held opcode.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mul_signed_r <= 1'b0;
`ifdef MDU_MADD_EN
            acc_en_r     <= 1'b0;
            acc_sub_r    <= 1'b0;
`endif
        end else if (go_s & is_mul_s) begin
            mul_signed_r <= is_signed_s;
`ifdef MDU_MADD_EN
            acc_en_r     <= acc_en_s;
            acc_sub_r    <= acc_sub_s;
`endif
        end
    end

    // Two 33x17 signed partial products; the low half of src_b is always non-negative.
    always_comb begin
        a_ext_s    = {mul_signed_r & src_a[31], src_a};
        b_lo_ext_s = {1'b0, src_b[15:0]};
        b_hi_ext_s = {mul_signed_r & src_b[31], src_b[31:16]};
        pp_lo_s    = 50'(a_ext_s) * 50'(b_lo_ext_s);
        pp_hi_s    = 50'(a_ext_s) * 50'(b_hi_ext_s);
        product_s  = 64'(pp_lo_r) + (64'(pp_hi_r) << 6'd16);
`ifdef MDU_MADD_EN
        if (acc_en_r) begin
            if (acc_sub_r) begin
                mul_res_s = {hi, lo} - product_s;
            end else begin
                mul_res_s = {hi, lo} + product_s;
            end
        end else begin
            mul_res_s = product_s;
        end
`else
        mul_res_s = product_s;
`endif
    end

    // Partial-product registers, loaded while in MUL1.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pp_lo_r <= 50'sd0;
            pp_hi_r <= 50'sd0;
        end else if (state_r == MUL1) begin
            pp_lo_r <= pp_lo_s;
            pp_hi_r <= pp_hi_s;
        end
    end

    // Next state and HI/LO write data; a flush always wins over a completing result.
    always_comb begin
        state_nxt_s = state_r;
        hi_nxt_s    = hi;
        lo_nxt_s    = lo;
        case (state_r)
            IDLE: begin
                if (go_s & is_mul_s) begin
                    state_nxt_s = MUL1;
                end else if (go_s & is_div_s) begin
                    state_nxt_s = DIVW;
                end else begin
                    state_nxt_s = IDLE;
                end
                if (go_s & (op == OP_MTHI)) begin
                    hi_nxt_s = src_a;
                end else begin
                    hi_nxt_s = hi;
                end
                if (go_s & (op == OP_MTLO)) begin
                    lo_nxt_s = src_a;
                end else begin
                    lo_nxt_s = lo;
                end
            end
            MUL1: begin
                if (ex_flush) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = MUL2;
                end
            end
            MUL2: begin
                if (ex_flush) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s          = DONE;
                    {hi_nxt_s, lo_nxt_s} = mul_res_s;
                end
            end
            DIVW: begin
                if (ex_flush) begin
                    state_nxt_s = IDLE;
                end else if (div_finish) begin
                    state_nxt_s = DONE;
                    hi_nxt_s    = div_r;
                    lo_nxt_s    = div_q;
                end else begin
                    state_nxt_s = DIVW;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Architectural HI/LO registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else begin
            hi <= hi_nxt_s;
            lo <= lo_nxt_s;
        end
    end

    // Pipeline stall and divider handshake; all held low while reset is asserted.
    always_comb begin
        stall      = 1'b0;
        div_en     = 1'b0;
        div_cancel = 1'b0;
        div_sign   = 1'b0;
        div_a      = 32'd0;
        div_b      = 32'd0;
        if (resetn) begin
            stall      = (go_s & (is_mul_s | is_div_s)) | (state_r == MUL1) |
                         (state_r == MUL2) | (state_r == DIVW);
            div_en     = go_s & is_div_s;
            div_cancel = (state_r == DIVW) & ex_flush;
        end else begin
            stall      = 1'b0;
            div_en     = 1'b0;
            div_cancel = 1'b0;
        end
        if (div_en) begin
            div_sign = (op == OP_DIV);
            div_a    = src_a;
            div_b    = src_b;
        end else begin
            div_sign = 1'b0;
            div_a    = 32'd0;
            div_b    = 32'd0;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: randomized and directed checks of mdu_ctrl against a transaction-level model;
// the bench also plays the role of the divider.
module tb_mdu_ctrl;

`ifdef MDU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        op_valid;
    logic [3:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        ex_flush;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_en;
    logic        div_sign;
    logic        div_cancel;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic        div_finish;

    int          checks;
    int          errors;
    int          stall_cnt;
    int          div_en_cnt;
    logic        exp_stall;
    logic        exp_div_en;
    logic        exp_div_sign;
    logic        exp_div_cancel;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic [31:0] exp_div_a;
    logic [31:0] exp_div_b;
    logic [31:0] nxt_hi;
    logic [31:0] nxt_lo;
    logic [63:0] pin;

    mdu_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .op_valid   (op_valid),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .ex_flush   (ex_flush),
        .stall      (stall),
        .hi         (hi),
        .lo         (lo),
        .div_en     (div_en),
        .div_sign   (div_sign),
        .div_cancel (div_cancel),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_q      (div_q),
        .div_r      (div_r),
        .div_finish (div_finish)
    );

    always #5 clk = ~clk;

    // {hi,lo} after a multiply-class op, from plain 64-bit arithmetic.
    function automatic logic [63:0] mul_model(input logic [3:0] o, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] acc);
        logic [63:0] p;
        if (o == 4'd1 || o == 4'd7 || o == 4'd9) p = 64'($signed(a)) * 64'($signed(b));
        else p = {32'd0, a} * {32'd0, b};
        if (o == 4'd7 || o == 4'd8) return acc + p;
        else if (o == 4'd9 || o == 4'd10) return acc - p;
        else return p;
    endfunction

    // {remainder, quotient}, truncating toward zero; divisor must be non-zero.
    function automatic logic [63:0] div_model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return {32'(sa % sb), 32'(sa / sb)};
        end
        return {a % b, a / b};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic compare_all();
        chk("stall", 32'(stall), 32'(exp_stall));
        chk("div_en", 32'(div_en), 32'(exp_div_en));
        chk("div_cancel", 32'(div_cancel), 32'(exp_div_cancel));
        chk("hi", hi, exp_hi);
        chk("lo", lo, exp_lo);
        if (exp_div_en) begin
            chk("div_sign", 32'(div_sign), 32'(exp_div_sign));
            chk("div_a", div_a, exp_div_a);
            chk("div_b", div_b, exp_div_b);
        end
        if (stall) stall_cnt++;
        if (div_en) div_en_cnt++;
    endtask

    // Check the current cycle at the falling edge, then open the next cycle with idle defaults.
    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
        exp_hi         = nxt_hi;
        exp_lo         = nxt_lo;
        resetn         = 1'b1;
        op_valid       = 1'b0;
        ex_flush       = 1'b0;
        div_finish     = 1'b0;
        op             = 4'($urandom);
        src_a          = $urandom;
        src_b          = $urandom;
        div_q          = $urandom;
        div_r          = $urandom;
        exp_stall      = 1'b0;
        exp_div_en     = 1'b0;
        exp_div_cancel = 1'b0;
    endtask

    // Issue one instruction; kill_at is the cycle offset of a flush (or reset), -1 for none.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int kill_at, input bit hold_done, input bit use_rst);
        bit          is_mul;
        bit          is_div;
        logic [63:0] qr;
        is_mul = (o == 4'd1) || (o == 4'd2) || (MADD_EN && o >= 4'd7 && o <= 4'd10);
        is_div = (o == 4'd3) || (o == 4'd4);
        qr     = 64'd0;
        step();
        op_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        if (kill_at == 0) begin
            ex_flush = 1'b1;
            return;
        end
        if (!is_mul && !is_div) begin
            if (o == 4'd5) nxt_hi = a;
            else if (o == 4'd6) nxt_lo = a;
            return;
        end
        exp_stall = 1'b1;
        if (is_div) begin
            exp_div_en   = 1'b1;
            exp_div_sign = (o == 4'd3);
            exp_div_a    = a;
            exp_div_b    = b;
            if (b == 32'd0) qr = {$urandom, $urandom};
            else qr = div_model(o == 4'd3, a, b);
        end
        for (int t = 1; t <= (is_div ? 17 : 2); t++) begin
            step();
            op_valid  = 1'b1;
            op        = o;
            src_a     = a;
            src_b     = b;
            exp_stall = 1'b1;
            if (is_div && t == 17) begin
                div_finish = 1'b1;
                div_r      = qr[63:32];
                div_q      = qr[31:0];
            end
            if (kill_at == t) begin
                if (use_rst) begin
                    resetn    = 1'b0;
                    exp_stall = 1'b0;
                    nxt_hi    = 32'd0;
                    nxt_lo    = 32'd0;
                end else begin
                    ex_flush       = 1'b1;
                    exp_div_cancel = is_div;
                end
                return;
            end
        end
        if (is_div) {nxt_hi, nxt_lo} = qr;
        else {nxt_hi, nxt_lo} = mul_model(o, a, b, {nxt_hi, nxt_lo});
        step();
        if (hold_done) begin
            op_valid = 1'b1;
            op       = o;
            src_a    = a;
            src_b    = b;
            ex_flush = 1'($urandom);
        end
    endtask

    initial begin
        checks = 0; errors = 0; stall_cnt = 0; div_en_cnt = 0;
        resetn = 1'b0; op_valid = 1'b0; op = 4'd0; src_a = 32'd0; src_b = 32'd0;
        ex_flush = 1'b0; div_finish = 1'b0; div_q = 32'd0; div_r = 32'd0;
        exp_stall = 1'b0; exp_div_en = 1'b0; exp_div_sign = 1'b0; exp_div_cancel = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0; exp_div_a = 32'd0; exp_div_b = 32'd0;
        nxt_hi = 32'd0; nxt_lo = 32'd0;

        // Reset with a DIV presented: nothing may start or stall.
        for (int i = 0; i < 3; i++) begin
            step();
            resetn   = 1'b0;
            op_valid = 1'b1;
            op       = 4'd3;
            nxt_hi   = 32'd0;
            nxt_lo   = 32'd0;
        end
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);

        // Model pins against hand-computed values.
        pin = mul_model(4'd1, 32'hFFFFFFFF, 32'd2, 64'd0);
        chk("pin_mult_hi", pin[63:32], 32'hFFFFFFFF);
        chk("pin_mult_lo", pin[31:0], 32'hFFFFFFFE);
        pin = div_model(1'b1, 32'hFFFFFFF9, 32'd2);
        chk("pin_div_q", pin[31:0], 32'hFFFFFFFD);
        chk("pin_div_r", pin[63:32], 32'hFFFFFFFF);

        stall_cnt = 0;
        run_op(4'd1, 32'hFFFFFFFF, 32'd2, -1, 1'b1, 1'b0);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFE);
        step();
        chk("mult_stall_cycles", 32'(stall_cnt), 32'd3);

        stall_cnt = 0;
        run_op(4'd2, 32'hFFFFFFFF, 32'd2, -1, 1'b0, 1'b0);
        chk("multu_hi", hi, 32'h00000001);
        chk("multu_lo", lo, 32'hFFFFFFFE);
        step();
        chk("multu_stall_cycles", 32'(stall_cnt), 32'd3);

        stall_cnt = 0; div_en_cnt = 0;
        run_op(4'd3, 32'hFFFFFFF9, 32'd2, -1, 1'b1, 1'b0);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);
        step();
        chk("div_stall_cycles", 32'(stall_cnt), 32'd18);
        chk("div_en_pulses", 32'(div_en_cnt), 32'd1);

        stall_cnt = 0;
        run_op(4'd4, 32'd100, 32'd7, 5, 1'b0, 1'b0);
        step();
        step();
        chk("divu_flush_stall_cycles", 32'(stall_cnt), 32'd6);
        chk("divu_flush_hi", hi, 32'hFFFFFFFF);
        chk("divu_flush_lo", lo, 32'hFFFFFFFD);

        stall_cnt = 0;
        run_op(4'd5, 32'h12345678, 32'd0, -1, 1'b0, 1'b0);
        run_op(4'd6, 32'h9ABCDEF0, 32'd0, -1, 1'b0, 1'b0);
        chk("mthi_hi", hi, 32'h12345678);
        step();
        chk("mtlo_lo", lo, 32'h9ABCDEF0);
        chk("mthi_mtlo_stall_cycles", 32'(stall_cnt), 32'd0);

        run_op(4'd5, 32'd0, 32'd0, -1, 1'b0, 1'b0);
        run_op(4'd6, 32'd1, 32'd0, -1, 1'b0, 1'b0);
        stall_cnt = 0;
        run_op(4'd7, 32'd3, 32'd4, -1, 1'b0, 1'b0);
        step();
        step();
        chk("madd_hi", hi, 32'd0);
        chk("madd_lo", lo, MADD_EN ? 32'd13 : 32'd1);
        chk("madd_stall_cycles", 32'(stall_cnt), MADD_EN ? 32'd3 : 32'd0);

        // Reset in the middle of a divide: abandoned without div_cancel.
        run_op(4'd4, 32'd50, 32'd3, 6, 1'b0, 1'b1);
        step();
        chk("divw_reset_hi", hi, 32'd0);
        chk("divw_reset_lo", lo, 32'd0);

        for (int i = 0; i < 300; i++) begin
            logic [3:0] o;
            logic [31:0] a;
            logic [31:0] b;
            int k;
            o = 4'($urandom_range(0, 15));
            a = pick();
            b = pick();
            if ($urandom_range(0, 3) == 0) k = $urandom_range(0, 18);
            else k = -1;
            run_op(o, a, b, k, 1'($urandom), 1'b0);
            repeat ($urandom_range(0, 2)) step();
        end

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
